// File: rtl/regbank_pkg.sv
// Shared definitions for the 16 x 16-bit general-purpose register bank.
package regbank_pkg;

    localparam int WIDTH     = 16;
    localparam int NREGS     = 16;
    localparam int REG_IDX_W = 4;

    // Write-back arbiter state: holding buffer empty or occupied.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } wb_state_e;

endpackage

// File: rtl/reg_decoder_4to16.sv
// Combinational 4-to-16 one-hot write-enable decoder for the register bank.
module reg_decoder_4to16
    import regbank_pkg::*;
(
    input  logic [REG_IDX_W-1:0] idx_i,
    input  logic                 en_i,
    output logic [NREGS-1:0]     onehot_o
);

    // Single enable bit at the selected index, all zero when disabled.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write side of the register bank: arbitrates ALU and load write-backs,
// parks a colliding load in a one-entry buffer, and holds r0..r15.
module reg_writeback
    import regbank_pkg::*;
#(
    parameter int WIDTH = regbank_pkg::WIDTH,
    parameter int NREGS = regbank_pkg::NREGS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_dest,
    input  logic [WIDTH-1:0]     alu_data,
    input  logic                 mem_valid,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic [WIDTH-1:0]     mem_data,
    output logic                 mem_ready,
    output logic                 hold_full,
    output logic [WIDTH-1:0]     r0,
    output logic [WIDTH-1:0]     r1,
    output logic [WIDTH-1:0]     r2,
    output logic [WIDTH-1:0]     r3,
    output logic [WIDTH-1:0]     r4,
    output logic [WIDTH-1:0]     r5,
    output logic [WIDTH-1:0]     r6,
    output logic [WIDTH-1:0]     r7,
    output logic [WIDTH-1:0]     r8,
    output logic [WIDTH-1:0]     r9,
    output logic [WIDTH-1:0]     r10,
    output logic [WIDTH-1:0]     r11,
    output logic [WIDTH-1:0]     r12,
    output logic [WIDTH-1:0]     r13,
    output logic [WIDTH-1:0]     r14,
    output logic [WIDTH-1:0]     r15
);

    wb_state_e            state_q;
    logic [REG_IDX_W-1:0] hold_dest_q;
    logic [WIDTH-1:0]     hold_data_q;
    logic [WIDTH-1:0]     regs_q [NREGS];

    logic                 wr_en_d;
    logic [REG_IDX_W-1:0] wr_dest_d;
    logic [WIDTH-1:0]     wr_data_d;
    logic [NREGS-1:0]     wr_onehot;

    // Write-select mux: ALU always wins, then the held load, then a fresh load.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_dest_d = alu_dest;
        wr_data_d = alu_data;
        if (alu_valid) begin
            wr_en_d = 1'b1;
        end else if (state_q == HOLD) begin
            wr_en_d   = 1'b1;
            wr_dest_d = hold_dest_q;
            wr_data_d = hold_data_q;
        end else if (mem_valid) begin
            wr_en_d   = 1'b1;
            wr_dest_d = mem_dest;
            wr_data_d = mem_data;
        end
    end

    reg_decoder_4to16 u_dec (
        .idx_i    (wr_dest_d),
        .en_i     (wr_en_d),
        .onehot_o (wr_onehot)
    );

    // Arbiter FSM and holding buffer: capture the load on a collision,
    // drain it on the first cycle without an ALU write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            hold_dest_q <= '0;
            hold_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (alu_valid && mem_valid) begin
                        state_q     <= HOLD;
                        hold_dest_q <= mem_dest;
                        hold_data_q <= mem_data;
                    end
                end
                HOLD: begin
                    if (!alu_valid) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Register bank: at most one register written per edge, cleared on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_onehot[i]) begin
                    regs_q[i] <= wr_data_d;
                end
            end
        end
    end

    // Handshake flags depend on state only, so no input reaches them combinationally.
    assign mem_ready = (state_q == IDLE);
    assign hold_full = (state_q == HOLD);

    assign r0  = regs_q[0];
    assign r1  = regs_q[1];
    assign r2  = regs_q[2];
    assign r3  = regs_q[3];
    assign r4  = regs_q[4];
    assign r5  = regs_q[5];
    assign r6  = regs_q[6];
    assign r7  = regs_q[7];
    assign r8  = regs_q[8];
    assign r9  = regs_q[9];
    assign r10 = regs_q[10];
    assign r11 = regs_q[11];
    assign r12 = regs_q[12];
    assign r13 = regs_q[13];
    assign r14 = regs_q[14];
    assign r15 = regs_q[15];

endmodule
